alu_job_sequencer: RTL

//  Queues operation jobs {a, b, op_code} for the shared 3-bit ALU datapath and issues them one at a time.

---
 rtl/alu_job_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_job_sequencer.sv
// alu_job_sequencer: job FIFO in front of the shared 3-bit ALU datapath.
// Jobs {a, b, op} are queued and issued one at a time. The operands are held
// on alu_* for RESULT_LAT edges. The ALU result is then captured and offered,
// together with the job that produced it, on the res_valid/res_ready port.
module alu_job_sequencer #(
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [2:0]                 job_a,
    input  logic [2:0]                 job_b,
    input  logic [1:0]                 job_op,
    output logic [2:0]                 alu_a,
    output logic [2:0]                 alu_b,
    output logic [1:0]                 alu_op,
    input  logic [5:0]                 final_in,
    input  logic                       carry,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [5:0]                 res_value,
    output logic                       res_carry,
    output logic [2:0]                 res_a,
    output logic [2:0]                 res_b,
    output logic [1:0]                 res_op,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] op;
    } job_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       lat_cnt_q, lat_cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    job_t [DEPTH-1:0]    mem_q, mem_d;
    logic [2:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic                res_valid_q, res_valid_d;
    logic [5:0]          res_value_q, res_value_d;
    logic                res_carry_q, res_carry_d;
    logic [2:0]          res_a_q, res_a_d, res_b_q, res_b_d;
    logic [1:0]          res_op_q, res_op_d;

    logic                push, pop;
    job_t                head;

    assign job_ready  = (count_q != CW'(DEPTH));
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign res_valid  = res_valid_q;
    assign res_value  = res_value_q;
    assign res_carry  = res_carry_q;
    assign res_a      = res_a_q;
    assign res_b      = res_b_q;
    assign res_op     = res_op_q;

    // Next-state: FIFO bookkeeping plus the IDLE -> WAIT -> HOLD issue sequencer.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_value_d = res_value_q;
        res_carry_d = res_carry_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_op_d    = res_op_q;
        head        = mem_q[rd_ptr_q];

        // Flush takes priority, so neither a push nor a pop happens on that edge.
        push = job_valid && job_ready && !flush;
        pop  = (state_q == S_IDLE) && (count_q != '0) && !flush;

        if (flush) begin
            // Drop queued and in-flight jobs. Operand and result data are left as they are.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            lat_cnt_d   = '0;
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{a: job_a, b: job_b, op: job_op};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        alu_a_d   = head.a;
                        alu_b_d   = head.b;
                        alu_op_d  = head.op;
                        res_a_d   = head.a;
                        res_b_d   = head.b;
                        res_op_d  = head.op;
                        lat_cnt_d = '0;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The result is sampled exactly RESULT_LAT edges after the issue edge.
                    if (lat_cnt_q == LW'(RESULT_LAT - 1)) begin
                        res_value_d = final_in;
                        res_carry_d = carry;
                        res_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LW'(1);
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers. An asynchronous reset clears every register to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_value_q <= '0;
            res_carry_q <= 1'b0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_value_q <= res_value_d;
            res_carry_q <= res_carry_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            res_op_q    <= res_op_d;
        end
    end

endmodule
